// File: rtl/skid_rr_arbiter_if.sv
// Handshake bundle between NUM_REQ upstream requesters, the round-robin arbiter
// and the downstream skid buffer. The arbiter uses the master view.
interface skid_rr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]            s_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] s_data;
   logic [NUM_REQ-1:0]            s_last;
   logic [NUM_REQ-1:0]            s_ready;
   logic                          m_valid;
   logic [DATA_WIDTH-1:0]         m_data;
   logic                          m_last;
   logic [ID_WIDTH-1:0]           m_id;
   logic                          m_ready;

   modport master (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_data, m_last, m_id
   );

   modport slave (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_data, m_last, m_id
   );
endinterface

// File: rtl/skid_rr_arbiter.sv
// Packet-locked round-robin arbiter: one IDLE cycle picks a requester, which then
// owns the downstream channel until its last beat is accepted.
module skid_rr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic              clk,
   input  logic              reset,
   skid_rr_arbiter_if.master bus,
   output logic              busy,
   output logic              pkt_done
);
   localparam int SW = ID_WIDTH + 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t              state;
   logic [ID_WIDTH-1:0] grant;
   logic [ID_WIDTH-1:0] rr_ptr;
   logic [ID_WIDTH-1:0] winner;
   logic [ID_WIDTH-1:0] next_ptr;
   logic                found;
   logic [SW-1:0]       scan;
   logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign data_arr[i] = bus.s_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      // NOTE: every variable gets a default before the conditional logic so no latch is inferred.
      winner = '0;
      found  = 1'b0;
      scan   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan = {1'b0, rr_ptr} + SW'(i);
         if (scan >= SW'(NUM_REQ)) scan = scan - SW'(NUM_REQ);
         if (!found && bus.s_valid[scan[ID_WIDTH-1:0]]) begin
            found  = 1'b1;
            winner = scan[ID_WIDTH-1:0];
         end
      end
   end

   assign next_ptr = (grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant + ID_WIDTH'(1);

   always_comb begin
      bus.s_ready = '0;
      bus.m_valid = 1'b0;
      bus.m_data  = '0;
      bus.m_last  = 1'b0;
      bus.m_id    = '0;
      if (state == LOCKED) begin
         bus.s_ready[grant] = bus.m_ready;
         bus.m_valid        = bus.s_valid[grant];
         bus.m_data         = data_arr[grant];
         bus.m_last         = bus.s_last[grant];
         bus.m_id           = grant;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state    <= IDLE;
         grant    <= '0;
         rr_ptr   <= '0;
         busy     <= 1'b0;
         pkt_done <= 1'b0;
      end else begin
         pkt_done <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  grant <= winner;
                  state <= LOCKED;
                  busy  <= 1'b1;
               end
            end
            LOCKED: begin
               if (bus.m_valid && bus.m_ready && bus.m_last) begin
                  rr_ptr   <= next_ptr;
                  state    <= IDLE;
                  busy     <= 1'b0;
                  pkt_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_skid_rr_arbiter.sv
// Scoreboard bench for skid_rr_arbiter: a 4-requester instance for the main
// scenarios and a 3-requester instance for non-power-of-two pointer wrap.
`timescale 1ns/1ps
module tb_skid_rr_arbiter;
   localparam int NA = 4;
   localparam int NB = 3;
   localparam int DW = 32;
   localparam int IA = $clog2(NA);
   localparam int IB = $clog2(NB);

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic [3:0]    gap;
   } beat_t;

   typedef struct packed {
      logic [3:0]    id;
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic busy_a, done_a, busy_b, done_b;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   skid_rr_arbiter_if #(.NUM_REQ(NA), .DATA_WIDTH(DW)) a_if ();
   skid_rr_arbiter_if #(.NUM_REQ(NB), .DATA_WIDTH(DW)) b_if ();

   skid_rr_arbiter #(.NUM_REQ(NA), .DATA_WIDTH(DW)) dut_a (
      .clk(clk), .reset(reset), .bus(a_if), .busy(busy_a), .pkt_done(done_a)
   );

   skid_rr_arbiter #(.NUM_REQ(NB), .DATA_WIDTH(DW)) dut_b (
      .clk(clk), .reset(reset), .bus(b_if), .busy(busy_b), .pkt_done(done_b)
   );

   beat_t         src_a [NA][$];
   bit            loaded_a [NA];
   int            wait_a [NA];
   bit [NA-1:0]   acc_a;
   exp_t          exp_a [$];
   exp_t          ea;
   int            log_cyc [$];
   int            done_cnt_a = 0;

   logic [DW-1:0] src_b [NB][$];
   bit [NB-1:0]   acc_b;
   exp_t          exp_b [$];
   exp_t          eb;

   // Requester models: hold each beat until accepted, optional idle gap before a beat.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NA; i++) begin
         if (reset) begin
            src_a[i].delete();
            loaded_a[i] = 1'b0;
            wait_a[i]   = 0;
         end else if (acc_a[i] && src_a[i].size() > 0) begin
            void'(src_a[i].pop_front());
            loaded_a[i] = 1'b0;
         end
         if (!loaded_a[i] && src_a[i].size() > 0) begin
            loaded_a[i] = 1'b1;
            wait_a[i]   = int'(src_a[i][0].gap);
         end
         if (loaded_a[i] && wait_a[i] > 0) begin
            a_if.s_valid[i] = 1'b0;
            wait_a[i]--;
         end else begin
            a_if.s_valid[i] = loaded_a[i];
         end
         a_if.s_data[i*DW +: DW] = loaded_a[i] ? src_a[i][0].data : '0;
         a_if.s_last[i]          = loaded_a[i] ? src_a[i][0].last : 1'b0;
      end
   end

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NB; i++) begin
         if (reset) src_b[i].delete();
         else if (acc_b[i] && src_b[i].size() > 0) void'(src_b[i].pop_front());
         b_if.s_valid[i]         = src_b[i].size() > 0;
         b_if.s_last[i]          = 1'b1;
         b_if.s_data[i*DW +: DW] = (src_b[i].size() > 0) ? src_b[i][0] : '0;
      end
   end

   always @(negedge clk) begin
      acc_a = a_if.s_valid & a_if.s_ready;
      if (done_a) done_cnt_a++;
      checks++;
      if ((a_if.s_ready & ~(NA'(1) << a_if.m_id)) !== '0) begin
         errors++;
         $display("FAIL ready_onehot_a: s_ready=%b with m_id=%0d, expected only the granted bit", a_if.s_ready, a_if.m_id);
      end
      if (!reset && a_if.m_valid && a_if.m_ready) begin
         log_cyc.push_back(cyc);
         checks++;
         if (exp_a.size() == 0) begin
            errors++;
            $display("FAIL beat_a: got id=%0d data=%h, expected no beat", a_if.m_id, a_if.m_data);
         end else begin
            ea = exp_a.pop_front();
            if ({a_if.m_id, a_if.m_data, a_if.m_last} !== {ea.id[IA-1:0], ea.data, ea.last}) begin
               errors++;
               $display("FAIL beat_a: got id=%0d data=%h last=%b, expected id=%0d data=%h last=%b",
                        a_if.m_id, a_if.m_data, a_if.m_last, ea.id, ea.data, ea.last);
            end
         end
      end
   end

   always @(negedge clk) begin
      acc_b = b_if.s_valid & b_if.s_ready;
      if (!reset && b_if.m_valid && b_if.m_ready) begin
         checks++;
         if (exp_b.size() == 0) begin
            errors++;
            $display("FAIL beat_b: got id=%0d data=%h, expected no beat", b_if.m_id, b_if.m_data);
         end else begin
            eb = exp_b.pop_front();
            if ({b_if.m_id, b_if.m_data} !== {eb.id[IB-1:0], eb.data}) begin
               errors++;
               $display("FAIL beat_b: got id=%0d data=%h, expected id=%0d data=%h",
                        b_if.m_id, b_if.m_data, eb.id, eb.data);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic send_a(input int req, input logic [DW-1:0] data, input bit last, input int gap);
      beat_t b;
      b.data = data;
      b.last = last;
      b.gap  = 4'(gap);
      src_a[req].push_back(b);
   endtask

   task automatic expect_a(input int id, input logic [DW-1:0] data, input bit last);
      exp_t e;
      e.id   = 4'(id);
      e.data = data;
      e.last = last;
      exp_a.push_back(e);
   endtask

   task automatic drain_a(input int bound, input string name);
      int k;
      for (k = 0; k < bound && exp_a.size() != 0; k++) @(negedge clk);
      checks++;
      if (exp_a.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d beats outstanding after %0d cycles, expected 0", name, exp_a.size(), bound);
      end
      step();
      step();
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      exp_a.delete();
      exp_b.delete();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) step();
      checks += 2;
      if ({a_if.s_ready, a_if.m_valid, a_if.m_data, a_if.m_last, a_if.m_id, busy_a, done_a} !== '0) begin
         errors++;
         $display("FAIL reset_a: outputs v=%b d=%h id=%0d busy=%b, expected all zero", a_if.m_valid, a_if.m_data, a_if.m_id, busy_a);
      end
      if ({b_if.s_ready, b_if.m_valid, b_if.m_data, b_if.m_last, b_if.m_id, busy_b, done_b} !== '0) begin
         errors++;
         $display("FAIL reset_b: outputs v=%b d=%h id=%0d busy=%b, expected all zero", b_if.m_valid, b_if.m_data, b_if.m_id, busy_b);
      end
      reset = 1'b0;
      step();
      checks++;
      if ({a_if.m_valid, busy_a, done_a, a_if.s_ready} !== '0) begin
         errors++;
         $display("FAIL idle_after_reset: v=%b busy=%b done=%b ready=%b, expected zero", a_if.m_valid, busy_a, done_a, a_if.s_ready);
      end
   endtask

   task automatic test_single();
      int sv_c, mv_c, base, d0;
      sv_c = -1;
      mv_c = -1;
      base = log_cyc.size();
      d0   = done_cnt_a;
      a_if.m_ready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         send_a(1, DW'(32'hA0 + b), b == 2, 0);
         expect_a(1, DW'(32'hA0 + b), b == 2);
      end
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (sv_c < 0 && a_if.s_valid[1]) sv_c = cyc;
         if (mv_c < 0 && a_if.m_valid) mv_c = cyc;
      end
      step();
      checks += 6;
      if (sv_c < 0 || mv_c != sv_c + 1) begin
         errors++;
         $display("FAIL single_latency: m_valid at %0d, s_valid at %0d, expected one IDLE cycle", mv_c, sv_c);
      end
      if (log_cyc.size() - base != 3 || log_cyc[log_cyc.size()-1] - log_cyc[base] != 2) begin
         errors++;
         $display("FAIL single_beats: %0d beats, expected 3 on consecutive cycles", log_cyc.size() - base);
      end
      if (done_cnt_a - d0 != 1) begin
         errors++;
         $display("FAIL single_done: %0d pkt_done pulses, expected 1", done_cnt_a - d0);
      end
      if (busy_a !== 1'b0) begin
         errors++;
         $display("FAIL single_busy: busy=%b, expected 0", busy_a);
      end
      if (dut_a.rr_ptr !== 2'd2) begin
         errors++;
         $display("FAIL single_rr_ptr: rr_ptr=%0d, expected 2", dut_a.rr_ptr);
      end
      if (exp_a.size() != 0) begin
         errors++;
         $display("FAIL single_drain: %0d beats missing, expected 0", exp_a.size());
      end
   endtask

   task automatic test_all_four();
      int base, d0, bad;
      pulse_reset();
      base = log_cyc.size();
      d0   = done_cnt_a;
      a_if.m_ready = 1'b1;
      for (int r = 0; r < NA; r++)
         for (int b = 0; b < 2; b++) send_a(r, DW'(16 * r + b), b == 1, 0);
      for (int b = 0; b < 2; b++) send_a(0, DW'(32'h50 + b), b == 1, 0);
      for (int r = 0; r < NA; r++)
         for (int b = 0; b < 2; b++) expect_a(r, DW'(16 * r + b), b == 1);
      for (int b = 0; b < 2; b++) expect_a(0, DW'(32'h50 + b), b == 1);
      drain_a(80, "all_four_drain");
      bad = 0;
      for (int j = base + 1; j < log_cyc.size(); j++)
         if (log_cyc[j] - log_cyc[j-1] != (((j - base) % 2 == 0) ? 2 : 1)) bad++;
      checks += 2;
      if (bad != 0 || log_cyc.size() - base != 10) begin
         errors++;
         $display("FAIL all_four_spacing: %0d bad gaps over %0d beats, expected 0 over 10", bad, log_cyc.size() - base);
      end
      if (done_cnt_a - d0 != 5) begin
         errors++;
         $display("FAIL all_four_done: %0d pkt_done pulses, expected 5", done_cnt_a - d0);
      end
   endtask

   task automatic test_backpressure();
      bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [DW-1:0] seen [5];
      int accepted, other_bad, k;
      bit locked;
      accepted  = 0;
      other_bad = 0;
      locked    = 1'b0;
      a_if.m_ready = 1'b0;
      for (int b = 0; b < 3; b++) begin
         send_a(2, DW'(32'hC0 + b), b == 2, 0);
         expect_a(2, DW'(32'hC0 + b), b == 2);
      end
      send_a(0, 32'h0D, 1'b1, 0);
      expect_a(0, 32'h0D, 1'b1);
      for (k = 0; k < 10 && !locked; k++) begin
         step();
         locked = busy_a && (a_if.m_id == 2'd2);
      end
      checks++;
      if (!locked) begin
         errors++;
         $display("FAIL bp_lock: requester 2 not granted within 10 cycles, expected grant");
      end
      for (int c = 0; c < 5; c++) begin
         a_if.m_ready = pat[c];
         @(negedge clk);
         seen[c] = a_if.m_data;
         if (a_if.m_valid && a_if.m_ready) accepted++;
         if ((a_if.s_ready & 4'b1011) !== 4'b0000) other_bad++;
         step();
      end
      checks += 4;
      if (accepted != 3) begin
         errors++;
         $display("FAIL bp_count: %0d beats accepted in 5 cycles, expected 3", accepted);
      end
      if (seen[1] !== 32'hC1 || seen[2] !== 32'hC1) begin
         errors++;
         $display("FAIL bp_hold: m_data %h,%h while stalled, expected c1,c1", seen[1], seen[2]);
      end
      if (other_bad != 0) begin
         errors++;
         $display("FAIL bp_others: %0d cycles with foreign s_ready, expected 0", other_bad);
      end
      if (busy_a !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: busy=%b after last beat, expected 0", busy_a);
      end
      a_if.m_ready = 1'b1;
      drain_a(20, "bp_drain");
   endtask

   task automatic test_gap();
      int base, gap_cycles;
      base       = log_cyc.size();
      gap_cycles = 0;
      a_if.m_ready = 1'b1;
      send_a(1, 32'hB0, 1'b0, 0);
      send_a(1, 32'hB1, 1'b0, 2);
      send_a(1, 32'hB2, 1'b1, 0);
      send_a(3, 32'h30, 1'b1, 0);
      expect_a(1, 32'hB0, 1'b0);
      expect_a(1, 32'hB1, 1'b0);
      expect_a(1, 32'hB2, 1'b1);
      expect_a(3, 32'h30, 1'b1);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (busy_a && a_if.m_id == 2'd1 && !a_if.m_valid) gap_cycles++;
      end
      drain_a(10, "gap_drain");
      checks += 2;
      if (gap_cycles != 2) begin
         errors++;
         $display("FAIL gap_valid: %0d locked cycles with m_valid low, expected 2", gap_cycles);
      end
      if (log_cyc.size() - base != 4 ||
          log_cyc[base+1] - log_cyc[base] != 3 ||
          log_cyc[base+2] - log_cyc[base+1] != 1 ||
          log_cyc[base+3] - log_cyc[base+2] != 2) begin
         errors++;
         $display("FAIL gap_timing: %0d beats with wrong spacing, expected 4 at +3,+1,+2", log_cyc.size() - base);
      end
   endtask

   task automatic test_reset_mid();
      int base, k;
      a_if.m_ready = 1'b1;
      send_a(2, 32'h2E, 1'b1, 0);
      expect_a(2, 32'h2E, 1'b1);
      drain_a(10, "mid_setup");
      base = log_cyc.size();
      for (int b = 0; b < 4; b++) begin
         send_a(1, DW'(32'h1A + b), b == 3, 0);
         expect_a(1, DW'(32'h1A + b), b == 3);
      end
      for (k = 0; k < 20 && log_cyc.size() == base; k++) step();
      reset = 1'b1;
      exp_a.delete();
      #1;
      checks += 2;
      if ({a_if.s_ready, a_if.m_valid, a_if.m_data, a_if.m_last, a_if.m_id, busy_a} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs: v=%b d=%h id=%0d busy=%b, expected all zero", a_if.m_valid, a_if.m_data, a_if.m_id, busy_a);
      end
      if (log_cyc.size() - base != 1) begin
         errors++;
         $display("FAIL mid_reset_beats: %0d beats before reset, expected 1", log_cyc.size() - base);
      end
      step();
      reset = 1'b0;
      repeat (2) step();
      send_a(3, 32'h3F, 1'b1, 0);
      send_a(0, 32'h0F, 1'b1, 0);
      expect_a(0, 32'h0F, 1'b1);
      expect_a(3, 32'h3F, 1'b1);
      drain_a(20, "mid_reset_drain");
   endtask

   task automatic test_wrap();
      int k;
      b_if.m_ready = 1'b1;
      for (int p = 0; p < 3; p++) begin
         src_b[1].push_back(DW'(32'h100 + p));
         src_b[2].push_back(DW'(32'h200 + p));
      end
      for (int p = 0; p < 3; p++) begin
         eb.id = 4'd1; eb.data = DW'(32'h100 + p); eb.last = 1'b1; exp_b.push_back(eb);
         eb.id = 4'd2; eb.data = DW'(32'h200 + p); eb.last = 1'b1; exp_b.push_back(eb);
      end
      for (k = 0; k < 40 && exp_b.size() != 0; k++) @(negedge clk);
      step();
      checks += 2;
      if (exp_b.size() != 0) begin
         errors++;
         $display("FAIL wrap_drain: %0d beats outstanding, expected 0", exp_b.size());
      end
      if (dut_b.rr_ptr !== 2'd0) begin
         errors++;
         $display("FAIL wrap_ptr: rr_ptr=%0d after requester 2, expected 0", dut_b.rr_ptr);
      end
   endtask

   initial begin
      reset        = 1'b1;
      a_if.m_ready = 1'b0;
      b_if.m_ready = 1'b0;
      test_reset();
      test_single();
      test_all_four();
      test_backpressure();
      test_gap();
      test_reset_mid();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at 100us, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/skid_rr_arbiter.md
Name: skid_rr_arbiter

Overview:
Round-robin, packet-locked arbiter that shares one downstream valid/ready channel among NUM_REQ upstream requesters. It sits directly in front of skid_buffer and drives skid_buffer's s_valid/s_data/s_ready. Output paths are combinational through the grant mux; skid_buffer provides the timing break. A grant is held from the first beat of a packet until its last beat is accepted, so packets from different requesters are never interleaved.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 32, payload width per beat
ID_WIDTH, $clog2(NUM_REQ), width of the granted-requester index

Ports:
clk  input  1  single clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
s_valid  input  NUM_REQ  per-requester beat valid
s_data  input  NUM_REQ*DATA_WIDTH  per-requester payload; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
s_last  input  NUM_REQ  per-requester last-beat-of-packet flag
s_ready  output  NUM_REQ  per-requester beat accepted when s_valid[i]&s_ready[i]
m_valid  output  1  to skid_buffer s_valid
m_data  output  DATA_WIDTH  to skid_buffer s_data
m_last  output  1  last beat of current packet
m_id  output  ID_WIDTH  index of the granted requester
m_ready  input  1  from skid_buffer s_ready
busy  output  1  high while in LOCKED
pkt_done  output  1  registered one-cycle pulse, cycle after a last beat is accepted

Behaviour:
- Reset (async assert): state=IDLE, grant=0, rr_ptr=0, pkt_done=0. During and after reset, s_ready=0, m_valid=0, m_last=0, m_data=0, m_id=0, busy=0.
- States:
  - IDLE: all s_ready=0, m_valid=0. If any s_valid is high, select the winner: the first i with s_valid[i]=1, searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ. Register grant=winner and go to LOCKED. Arbitration costs exactly one cycle, and no beat transfers in IDLE.
  - LOCKED: m_valid=s_valid[grant], m_data=s_data[grant], m_last=s_last[grant], m_id=grant. s_ready[grant]=m_ready; all other s_ready=0. busy=1.
  - Each cycle with m_valid&m_ready is one transferred beat.
  - If that beat has m_last=1: rr_ptr<=(grant+1) mod NUM_REQ (correct wrap for non-power-of-two NUM_REQ), pkt_done<=1 next cycle, state<=IDLE.
- Minimum spacing between packets: one IDLE cycle between consecutive packets, including when the same requester is the only one requesting.
- Outside IDLE/LOCKED m_data/m_last/m_id are 0.
- Boundary cases:
  - Granted requester drops s_valid mid-packet: lock held, m_valid=0 during the gap, other requesters stay blocked.
  - m_ready low: m_valid/m_data held from the granted requester. The requester must hold data per the valid/ready rules. No state change.
  - Single-beat packet (s_last on first beat): LOCKED for exactly the accepting cycle(s), then IDLE.
  - Requesters asserting s_valid while another is locked: they wait. Their order is set by rr_ptr at the next IDLE.
  - Requester that won arbitration lowers s_valid before its first beat: stays LOCKED until it sends a last beat. Requesters must not withdraw a request, and the checker flags it.
  - Reset mid-packet: immediate return to reset values. The partial packet is abandoned and the downstream sees no further beats from it.
- No combinational path from m_ready to m_valid.

Test Plan:
- Single requester 1 sends 3 beats 0xA0,0xA1,0xA2 (last on 0xA2), m_ready=1 -> IDLE 1 cycle, then m_data A0,A1,A2 on consecutive cycles, m_id=1, pkt_done pulses once, busy falls, rr_ptr=2.
- After reset, all 4 requesters each hold one 2-beat packet (data 0x10*i+beat) -> packets appear in order id 0,1,2,3, never interleaved; requester 0 re-requests and is served after 3.
- Requester 2 locked with m_ready toggled 1,0,0,1,1 on a 3-beat packet -> m_data stable while m_ready=0; exactly 3 beats accepted in 5 cycles; s_ready[other]=0 throughout.
- Granted requester inserts a 2-cycle s_valid gap mid-packet while requester 3 requests -> m_valid=0 in gap, no beats from 3 until after the last beat plus one IDLE cycle.
- Reset asserted between beats 1 and 2 of a 4-beat packet -> outputs zero same cycle; after release, a new request from requester 0 is granted first (rr_ptr=0).
- NUM_REQ=3 instance, requesters 1 and 2 always requesting with single-beat packets -> alternating m_id 1,2,1,2, with the pointer wrapping 2->0 correctly.
